// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues icache word reads, buffers a
// word that returns while IF/ID is stalled, and applies redirects and halt.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        stall_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc4_out,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic [31:0] fetch_cnt,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_buf_q;
  logic [31:0] fetch_cnt_q;
  logic [31:0] fetch_cnt_d;
  logic [31:0] pc4;
  logic [31:0] redirect_target;
  logic        deliver;

  assign pc4             = pc_q + 32'd4;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  assign iREN       = (state_q == FETCH);
  assign iaddr      = pc_q;
  assign pc4_out    = pc4;
  assign instr_out  = (state_q == HOLD) ? instr_buf_q : iload;
  assign halted     = (state_q == HALTED);
  assign ifid_flush = redirect_valid & ~halt_in & (state_q != HALTED);
  assign ifid_en    = ifid_flush |
                      (~halt_in & ~stall_in &
                       (((state_q == FETCH) & ihit) | (state_q == HOLD)));

  // A flushed slot is not a delivered instruction, so it is not counted.
  assign deliver     = ifid_en & ~ifid_flush;
  assign fetch_cnt_d = fetch_cnt_q + {31'd0, deliver};
  assign fetch_cnt   = fetch_cnt_q;

  // Fetch FSM, PC, stall buffer and delivery counter; halt beats redirect beats hit/stall.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= FETCH;
      pc_q        <= PC_INIT;
      instr_buf_q <= '0;
      fetch_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      case (state_q)
        FETCH: begin
          if (halt_in) begin
            state_q <= HALTED;
          end else if (redirect_valid) begin
            // Any word returning this cycle belongs to the wrong path.
            pc_q <= redirect_target;
          end else if (ihit) begin
            if (stall_in) begin
              instr_buf_q <= iload;
              state_q     <= HOLD;
            end else begin
              pc_q <= pc4;
            end
          end
        end
        HOLD: begin
          if (halt_in) begin
            state_q <= HALTED;
          end else if (redirect_valid) begin
            pc_q        <= redirect_target;
            instr_buf_q <= '0;
            state_q     <= FETCH;
          end else if (!stall_in) begin
            pc_q    <= pc4;
            state_q <= FETCH;
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming hits, misses, stall buffering,
// redirects from FETCH and HOLD, halt priority, and PC/counter wraparound.
module tb_fetch_stage;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        ihit;
  logic [31:0] iload;
  logic        stall_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_in;
  logic [31:0] instr_out;
  logic [31:0] pc4_out;
  logic        ifid_en;
  logic        ifid_flush;
  logic [31:0] fetch_cnt;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .iREN           (iREN),
    .iaddr          (iaddr),
    .ihit           (ihit),
    .iload          (iload),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_in        (halt_in),
    .instr_out      (instr_out),
    .pc4_out        (pc4_out),
    .ifid_en        (ifid_en),
    .ifid_flush     (ifid_flush),
    .fetch_cnt      (fetch_cnt),
    .halted         (halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change at negedge; combinational checks happen 1 time unit later.
  task automatic drive(input logic hit, input logic [31:0] load, input logic stall,
                       input logic rv, input logic [31:0] rpc, input logic halt);
    @(negedge CLK);
    ihit = hit; iload = load; stall_in = stall;
    redirect_valid = rv; redirect_pc = rpc; halt_in = halt;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; ihit = 1'b0; iload = '0; stall_in = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; halt_in = 1'b0;
    tick();
    @(negedge CLK);
    RST = 1'b0;
    #1;
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; iload = '0; stall_in = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; halt_in = 1'b0;
    do_reset();

    // Reset state
    chk("rst_iren",   {31'd0, iREN}, 32'd1);
    chk("rst_iaddr",  iaddr, 32'h0);
    chk("rst_en",     {31'd0, ifid_en}, 32'd0);
    chk("rst_flush",  {31'd0, ifid_flush}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_cnt",    fetch_cnt, 32'd0);

    // Streaming hits at 0 and 4
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'hA000_0000 | (32'd4 * k), 1'b0, 1'b0, '0, 1'b0);
      chk("s_iaddr", iaddr, 32'd4 * k);
      chk("s_en",    {31'd0, ifid_en}, 32'd1);
      chk("s_instr", instr_out, 32'hA000_0000 | (32'd4 * k));
      chk("s_pc4",   pc4_out, 32'd4 * k + 32'd4);
      tick();
      chk("s_cnt",   fetch_cnt, k + 1);
    end

    // Miss for 3 cycles at pc=8
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, 1'b0);
      chk("m_iren",  {31'd0, iREN}, 32'd1);
      chk("m_iaddr", iaddr, 32'h8);
      chk("m_en",    {31'd0, ifid_en}, 32'd0);
      tick();
    end
    chk("m_cnt", fetch_cnt, 32'd2);
    drive(1'b1, 32'hA000_0008, 1'b0, 1'b0, '0, 1'b0);
    chk("m_hit_en", {31'd0, ifid_en}, 32'd1);
    tick();
    chk("m_adv_iaddr", iaddr, 32'hC);
    chk("m_adv_cnt",   fetch_cnt, 32'd3);
    drive(1'b1, 32'hA000_000C, 1'b0, 1'b0, '0, 1'b0);
    tick();
    chk("pc10", iaddr, 32'h10);

    // Stall at pc=0x10: word captured into HOLD, held 2 cycles
    drive(1'b1, 32'h1234_5678, 1'b1, 1'b0, '0, 1'b0);
    chk("st_en0", {31'd0, ifid_en}, 32'd0);
    tick();
    drive(1'b0, 32'hBAD0_BAD0, 1'b1, 1'b0, '0, 1'b0);
    chk("st_iren",  {31'd0, iREN}, 32'd0);
    chk("st_instr", instr_out, 32'h1234_5678);
    chk("st_en1",   {31'd0, ifid_en}, 32'd0);
    chk("st_iaddr", iaddr, 32'h10);
    tick();
    chk("st_cnt", fetch_cnt, 32'd4);
    drive(1'b0, 32'hBAD0_BAD0, 1'b0, 1'b0, '0, 1'b0);
    chk("rel_en",    {31'd0, ifid_en}, 32'd1);
    chk("rel_instr", instr_out, 32'h1234_5678);
    tick();
    chk("rel_iaddr", iaddr, 32'h14);
    chk("rel_iren",  {31'd0, iREN}, 32'd1);
    chk("rel_cnt",   fetch_cnt, 32'd5);

    // Redirect in FETCH with a same-cycle hit; low bits of target dropped
    drive(1'b1, 32'hA000_0014, 1'b0, 1'b1, 32'h0000_0203, 1'b0);
    chk("rf_en",    {31'd0, ifid_en}, 32'd1);
    chk("rf_flush", {31'd0, ifid_flush}, 32'd1);
    tick();
    chk("rf_iaddr", iaddr, 32'h200);
    chk("rf_cnt",   fetch_cnt, 32'd5);

    // Redirect out of HOLD while still stalled
    drive(1'b1, 32'h5555_AAAA, 1'b1, 1'b0, '0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0300, 1'b0);
    chk("rh_flush", {31'd0, ifid_flush}, 32'd1);
    chk("rh_en",    {31'd0, ifid_en}, 32'd1);
    tick();
    chk("rh_iaddr", iaddr, 32'h300);
    chk("rh_iren",  {31'd0, iREN}, 32'd1);
    chk("rh_cnt",   fetch_cnt, 32'd5);

    // Halt wins over a same-cycle redirect, then everything is ignored
    drive(1'b1, 32'hA000_0300, 1'b0, 1'b1, 32'h0000_0400, 1'b1);
    chk("h_flush", {31'd0, ifid_flush}, 32'd0);
    chk("h_en",    {31'd0, ifid_en}, 32'd0);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'hA000_0300, 1'b0, 1'b1, 32'h0000_0400, 1'b0);
      chk("hd_state", {28'd0, halted, iREN, ifid_en, ifid_flush}, 32'b1000);
      tick();
    end
    chk("hd_iaddr", iaddr, 32'h300);
    chk("hd_cnt",   fetch_cnt, 32'd5);
    do_reset();
    chk("hr_iaddr",  iaddr, 32'h0);
    chk("hr_iren",   {31'd0, iREN}, 32'd1);
    chk("hr_halted", {31'd0, halted}, 32'd0);
    chk("hr_cnt",    fetch_cnt, 32'd0);

    // Reset in the middle of HOLD drops the buffered word
    drive(1'b1, 32'h7777_7777, 1'b1, 1'b0, '0, 1'b0);
    tick();
    do_reset();
    chk("rh2_iren",  {31'd0, iREN}, 32'd1);
    chk("rh2_instr", instr_out, 32'h0);

    // PC wrap at 0xFFFF_FFFC and counter wrap at 0xFFFF_FFFF
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    tick();
    chk("w_iaddr", iaddr, 32'hFFFF_FFFC);
    @(negedge CLK);
    ihit = 1'b0; redirect_valid = 1'b0;
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    tick();
    @(negedge CLK);
    release dut.fetch_cnt_q;
    #1;
    chk("w_cnt_pre", fetch_cnt, 32'hFFFF_FFFF);
    drive(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, '0, 1'b0);
    chk("w_pc4", pc4_out, 32'h0);
    chk("w_en",  {31'd0, ifid_en}, 32'd1);
    tick();
    chk("w_iaddr0", iaddr, 32'h0);
    chk("w_cnt0",   fetch_cnt, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
